// File: rtl/elevator_call_scheduler_pkg.sv
// Shared types and default sizing for the elevator call scheduler.
// Defaults give a 4-floor car with a 64-cycle arrival watchdog.
package elevator_call_scheduler_pkg;

   localparam int DEF_NUM_FLOORS  = 4;
   localparam int DEF_FLOOR_W     = 2;
   localparam int DEF_TIMEOUT_CYC = 64;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SELECT    = 2'd1,
      ISSUE     = 2'd2,
      WAIT_DONE = 2'd3
   } sched_state_t;

endpackage

// File: rtl/elevator_target_sel.sv
// LOOK target picker: nearest pending floor ahead of the car in the sweep direction, else reverse.
// Pure combinational, zero latency; no flow control.
// No backpressure; the caller decides when the result is used.
module elevator_target_sel
   import elevator_call_scheduler_pkg::*;
#(
   parameter int NUM_FLOORS = DEF_NUM_FLOORS,
   parameter int FLOOR_W    = DEF_FLOOR_W
) (
   input  logic [NUM_FLOORS-1:0] pending,
   input  logic [FLOOR_W-1:0]    cur_floor,
   input  logic                  sweep_up,
   output logic [FLOOR_W-1:0]    target,
   output logic                  new_sweep_up,
   output logic                  found
);

   logic               up_hit;
   logic               dn_hit;
   logic [FLOOR_W-1:0] up_floor;
   logic [FLOOR_W-1:0] dn_floor;

   // The car's own floor belongs to whichever side the current sweep faces.
   always_comb begin
      up_hit   = 1'b0;
      dn_hit   = 1'b0;
      up_floor = '0;
      dn_floor = '0;
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (pending[i] && ((FLOOR_W'(i) > cur_floor) ||
                            ((FLOOR_W'(i) == cur_floor) && sweep_up))) begin
            up_hit   = 1'b1;
            up_floor = FLOOR_W'(i);
         end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending[i] && ((FLOOR_W'(i) < cur_floor) ||
                            ((FLOOR_W'(i) == cur_floor) && !sweep_up))) begin
            dn_hit   = 1'b1;
            dn_floor = FLOOR_W'(i);
         end
      end
   end

   always_comb begin
      found        = up_hit | dn_hit;
      new_sweep_up = sweep_up;
      target       = '0;
      if (sweep_up) begin
         if (up_hit) begin
            target = up_floor;
         end else if (dn_hit) begin
            target       = dn_floor;
            new_sweep_up = 1'b0;
         end
      end else begin
         if (dn_hit) begin
            target = dn_floor;
         end else if (up_hit) begin
            target       = up_floor;
            new_sweep_up = 1'b1;
         end
      end
   end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Latches floor calls, issues LOOK-ordered targets to the elevator and retires them on arrival.
// Latency: a call into an idle scheduler raises req_valid 3 edges later.
// Backpressure: one request outstanding; waits for complete or a watchdog timeout.
module elevator_call_scheduler
   import elevator_call_scheduler_pkg::*;
#(
   parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
   parameter int FLOOR_W     = DEF_FLOOR_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] call_btn,
   input  logic [FLOOR_W-1:0]    cur_floor,
   input  logic                  complete,
   output logic [FLOOR_W-1:0]    req_floor,
   output logic                  req_valid,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  sweep_up,
   output logic                  busy,
   output logic                  fault
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   sched_state_t          state;
   sched_state_t          state_nxt;
   logic [NUM_FLOORS-1:0] pend_in;
   logic [NUM_FLOORS-1:0] clr_mask;
   logic [NUM_FLOORS-1:0] pending_nxt;
   logic [FLOOR_W-1:0]    req_floor_nxt;
   logic                  req_valid_nxt;
   logic                  sweep_up_nxt;
   logic                  fault_nxt;
   logic [CNT_W-1:0]      tmo_cnt;
   logic [CNT_W-1:0]      tmo_cnt_nxt;
   logic [CNT_W-1:0]      tmo_cnt_inc;
   logic [FLOOR_W-1:0]    sel_target;
   logic                  sel_sweep_up;
   logic                  sel_found;
   logic                  accept;

   assign pend_in     = pending | call_btn;
   assign tmo_cnt_inc = tmo_cnt + CNT_W'(1);
   assign busy        = (state != IDLE);

   // A zero counter marks the first WAIT_DONE cycle, where complete may still refer to the old target.
   assign accept = (state == WAIT_DONE) && complete && (cur_floor == req_floor) &&
                   (tmo_cnt != '0);

   elevator_target_sel #(
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_W    (FLOOR_W)
   ) u_target_sel (
      .pending      (pend_in),
      .cur_floor    (cur_floor),
      .sweep_up     (sweep_up),
      .target       (sel_target),
      .new_sweep_up (sel_sweep_up),
      .found        (sel_found)
   );

   always_comb begin
      clr_mask = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         clr_mask[i] = accept && (FLOOR_W'(i) == req_floor);
      end
      pending_nxt = pend_in & ~clr_mask;
   end

   always_comb begin
      state_nxt     = state;
      req_floor_nxt = req_floor;
      req_valid_nxt = req_valid;
      sweep_up_nxt  = sweep_up;
      fault_nxt     = fault;
      tmo_cnt_nxt   = tmo_cnt;
      case (state)
         IDLE: begin
            if (pending != '0) state_nxt = SELECT;
         end
         SELECT: begin
            if (sel_found) begin
               req_floor_nxt = sel_target;
               sweep_up_nxt  = sel_sweep_up;
               req_valid_nxt = 1'b1;
               state_nxt     = ISSUE;
            end else begin
               state_nxt = IDLE;
            end
         end
         ISSUE: begin
            tmo_cnt_nxt = '0;
            state_nxt   = WAIT_DONE;
         end
         WAIT_DONE: begin
            tmo_cnt_nxt = tmo_cnt_inc;
            if (accept) begin
               req_valid_nxt = 1'b0;
               state_nxt     = (pending_nxt != '0) ? SELECT : IDLE;
            end else if (tmo_cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
               // Give up on this target but keep the call; it is retried on the next sweep.
               fault_nxt     = 1'b1;
               req_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pending   <= '0;
         req_floor <= '0;
         req_valid <= 1'b0;
         sweep_up  <= 1'b1;
         fault     <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         pending   <= pending_nxt;
         req_floor <= req_floor_nxt;
         req_valid <= req_valid_nxt;
         sweep_up  <= sweep_up_nxt;
         fault     <= fault_nxt;
         tmo_cnt   <= tmo_cnt_nxt;
      end
   end

endmodule
